// File: rtl/mbist_resp_analyzer.sv
// MBIST read-side response analyzer: regenerates expected data from the background
// selector, compares strobed reads and accumulates pass/fail and first-fail results.
module mbist_resp_analyzer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              end_test,
    input  logic              cmp_en,
    input  logic [2:0]        q,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              pat_err,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [7:0]        fail_bits,
    output logic [ADDR_W-1:0] ff_addr,
    output logic [2:0]        ff_q,
    output logic [7:0]        ff_syn
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] exp_data;
    logic       q_bad;
    logic [7:0] syn;
    logic       accept;
    logic       strobe_fail;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        exp_data = 8'h00;
        q_bad    = 1'b0;
        case (q)
            3'b000:  exp_data = 8'hAA;
            3'b001:  exp_data = 8'h55;
            3'b010:  exp_data = 8'hF0;
            3'b011:  exp_data = 8'h0F;
            3'b100:  exp_data = 8'h00;
            3'b101:  exp_data = 8'hFF;
            default: q_bad    = 1'b1;
        endcase
    end

    // An invalid selector is reported as an all-bits failure.
    assign syn         = q_bad ? 8'hFF : (rdata ^ exp_data);
    assign accept      = cmp_en && (state == RUN) && !start;
    assign strobe_fail = accept && (syn != 8'h00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (start)         state_nxt = RUN;
                else if (end_test) state_nxt = DONE;
            end
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            pat_err   <= 1'b0;
            fail_cnt  <= '0;
            fail_bits <= 8'h00;
            ff_addr   <= '0;
            ff_q      <= 3'b000;
            ff_syn    <= 8'h00;
        end else if (start) begin
            fail      <= 1'b0;
            pat_err   <= 1'b0;
            fail_cnt  <= '0;
            fail_bits <= 8'h00;
            ff_addr   <= '0;
            ff_q      <= 3'b000;
            ff_syn    <= 8'h00;
        end else begin
            if (accept && q_bad) pat_err <= 1'b1;
            if (strobe_fail) begin
                fail      <= 1'b1;
                fail_bits <= fail_bits | syn;
                if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
                // Old value of fail: only the very first failing strobe is recorded.
                if (!fail) begin
                    ff_addr <= addr;
                    ff_q    <= q;
                    ff_syn  <= syn;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_resp_analyzer.sv
// Self-checking bench for mbist_resp_analyzer: vector table plus directed
// saturation and asynchronous-reset sequences.
module tb_mbist_resp_analyzer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, end_test, cmp_en;
    logic [2:0] q;
    logic [9:0] addr;
    logic [7:0] rdata;

    logic       busy, done, fail, pat_err;
    logic [7:0] fail_cnt, fail_bits, ff_syn;
    logic [9:0] ff_addr;
    logic [2:0] ff_q;

    logic       s_busy, s_done, s_fail, s_pat_err;
    logic [3:0] s_fail_cnt;
    logic [7:0] s_fail_bits, s_ff_syn;
    logic [9:0] s_ff_addr;
    logic [2:0] s_ff_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbist_resp_analyzer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_test(end_test), .cmp_en(cmp_en),
        .q(q), .addr(addr), .rdata(rdata), .busy(busy), .done(done), .fail(fail),
        .pat_err(pat_err), .fail_cnt(fail_cnt), .fail_bits(fail_bits),
        .ff_addr(ff_addr), .ff_q(ff_q), .ff_syn(ff_syn)
    );

    mbist_resp_analyzer #(.ADDR_W(10), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .end_test(end_test), .cmp_en(cmp_en),
        .q(q), .addr(addr), .rdata(rdata), .busy(s_busy), .done(s_done), .fail(s_fail),
        .pat_err(s_pat_err), .fail_cnt(s_fail_cnt), .fail_bits(s_fail_bits),
        .ff_addr(s_ff_addr), .ff_q(s_ff_q), .ff_syn(s_ff_syn)
    );

    typedef struct {
        logic       start, end_test, cmp_en;
        logic [2:0] q;
        logic [9:0] addr;
        logic [7:0] rdata;
        logic       busy, done, fail, pat_err;
        logic [7:0] cnt, bits;
        logic [9:0] ffa;
        logic [2:0] ffq;
        logic [7:0] ffs;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic c,
                         input logic [2:0] qq, input logic [9:0] a, input logic [7:0] d);
        start = s; end_test = e; cmp_en = c; q = qq; addr = a; rdata = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic b, input logic dn, input logic f,
                             input logic pe, input logic [7:0] cnt, input logic [7:0] bits,
                             input logic [9:0] ffa, input logic [2:0] ffq, input logic [7:0] ffs);
        check({tag, " busy"},      32'(busy),      32'(b));
        check({tag, " done"},      32'(done),      32'(dn));
        check({tag, " fail"},      32'(fail),      32'(f));
        check({tag, " pat_err"},   32'(pat_err),   32'(pe));
        check({tag, " fail_cnt"},  32'(fail_cnt),  32'(cnt));
        check({tag, " fail_bits"}, 32'(fail_bits), 32'(bits));
        check({tag, " ff_addr"},   32'(ff_addr),   32'(ffa));
        check({tag, " ff_q"},      32'(ff_q),      32'(ffq));
        check({tag, " ff_syn"},    32'(ff_syn),    32'(ffs));
    endtask

    function automatic vec_t mk(logic s, logic e, logic c, logic [2:0] qq, logic [9:0] a,
                                logic [7:0] d, logic b, logic dn, logic f, logic pe,
                                logic [7:0] cnt, logic [7:0] bits, logic [9:0] ffa,
                                logic [2:0] ffq, logic [7:0] ffs);
        vec_t v;
        v.start = s; v.end_test = e; v.cmp_en = c; v.q = qq; v.addr = a; v.rdata = d;
        v.busy = b; v.done = dn; v.fail = f; v.pat_err = pe; v.cnt = cnt; v.bits = bits;
        v.ffa = ffa; v.ffq = ffq; v.ffs = ffs;
        return v;
    endfunction

    initial begin
        logic [7:0] good [6];
        good[0] = 8'hAA; good[1] = 8'h55; good[2] = 8'hF0;
        good[3] = 8'h0F; good[4] = 8'h00; good[5] = 8'hFF;

        // Strobe in IDLE is ignored, then a clean pass over all six backgrounds.
        vecs[0] = mk(0,0,1,3'd6,10'd1,8'h00, 0,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[1] = mk(1,0,0,3'd0,10'd0,8'h00, 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        for (int i = 0; i < 6; i++)
            vecs[2+i] = mk(0,0,1,3'(i),10'(i),good[i], 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[8]  = mk(0,1,0,3'd0,10'd0,8'h00, 0,1,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        // Strobe in DONE is ignored.
        vecs[9]  = mk(0,0,1,3'd2,10'd7,8'hF1, 0,1,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        // First-fail capture: F1^F0=01 at addr 7, then 2A^AA=80 at addr 9.
        vecs[10] = mk(1,0,0,3'd0,10'd0,8'h00, 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[11] = mk(0,0,1,3'd2,10'd7,8'hF1, 1,0,1,0,8'd1,8'h01,10'd7,3'd2,8'h01);
        vecs[12] = mk(0,0,1,3'd0,10'd9,8'h2A, 1,0,1,0,8'd2,8'h81,10'd7,3'd2,8'h01);
        vecs[13] = mk(0,1,0,3'd0,10'd0,8'h00, 0,1,1,0,8'd2,8'h81,10'd7,3'd2,8'h01);
        // Restart from DONE clears results; invalid selector 110.
        vecs[14] = mk(1,0,0,3'd0,10'd0,8'h00, 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[15] = mk(0,0,1,3'd6,10'd3,8'h00, 1,0,1,1,8'd1,8'hFF,10'd3,3'd6,8'hFF);
        vecs[16] = mk(0,0,1,3'd1,10'd4,8'h55, 1,0,1,1,8'd1,8'hFF,10'd3,3'd6,8'hFF);
        // Failing strobe together with end_test: counted, then DONE.
        vecs[17] = mk(0,1,1,3'd3,10'd5,8'h0E, 0,1,1,1,8'd2,8'hFF,10'd3,3'd6,8'hFF);
        vecs[18] = mk(0,0,1,3'd7,10'd6,8'h00, 0,1,1,1,8'd2,8'hFF,10'd3,3'd6,8'hFF);
        // Start wins over a simultaneous strobe and over end_test.
        vecs[19] = mk(1,0,1,3'd7,10'd6,8'h00, 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[20] = mk(1,1,0,3'd0,10'd0,8'h00, 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        vecs[21] = mk(0,1,0,3'd0,10'd0,8'h00, 0,1,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);

        rst_n = 1'b0;
        drive(0,0,0,3'd0,10'd0,8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].start, vecs[i].end_test, vecs[i].cmp_en,
                  vecs[i].q, vecs[i].addr, vecs[i].rdata);
            cycle();
            check_all($sformatf("row%0d", i), vecs[i].busy, vecs[i].done, vecs[i].fail,
                      vecs[i].pat_err, vecs[i].cnt, vecs[i].bits, vecs[i].ffa,
                      vecs[i].ffq, vecs[i].ffs);
        end

        // Saturation: 20 failing strobes (00 expected, 01 read) into the 4-bit counter.
        drive(1,0,0,3'd0,10'd0,8'h00);
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(0,0,1,3'd4,10'(i),8'h01);
            cycle();
            check($sformatf("sat%0d cnt4", i), 32'(s_fail_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            check($sformatf("sat%0d cnt8", i), 32'(fail_cnt), 32'(i + 1));
        end
        drive(0,1,0,3'd0,10'd0,8'h00);
        cycle();
        drive(0,0,0,3'd0,10'd0,8'h00);
        cycle();
        check("sat hold cnt4", 32'(s_fail_cnt), 32'd15);
        check("sat hold done", 32'(s_done), 32'd1);
        check("sat ff_addr", 32'(s_ff_addr), 32'd0);

        // Asynchronous reset between edges mid-RUN after a fail.
        drive(1,0,0,3'd0,10'd0,8'h00);
        cycle();
        drive(0,0,1,3'd5,10'd12,8'h7F);
        cycle();
        check_all("pre_rst", 1,0,1,0,8'd1,8'h80,10'd12,3'd5,8'h80);
        drive(0,0,0,3'd0,10'd0,8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 0,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,1,3'd6,10'd2,8'h00);
        cycle();
        check_all("post_rst_strobe", 0,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        drive(1,0,0,3'd0,10'd0,8'h00);
        cycle();
        check_all("post_rst_start", 1,0,0,0,8'd0,8'h00,10'd0,3'd0,8'h00);
        drive(0,0,0,3'd0,10'd0,8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
